bcd_score_tracker: RTL and testbench
====================================

Name: bcd_score_tracker

Overview:
- Parametrised successor to the 16-bit binary score counter.
- Keeps the running game score in packed BCD, so each nibble drives a seven-segment decoder directly as a decimal digit.
- Accepts variable point awards, saturates at the all-nines ceiling, and tracks a session high score with a new-record pulse.
- Sits between game-logic event generators and the per-digit display decoders.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in the score; legal range 1..8.
- MAX_ADD, 9, largest accepted award per add; any add_value above it is clamped to MAX_ADD; legal range 1..9.

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  synchronous, active-low reset.
- enable  input  1  game-active; low clears current score (high score retained).
- add_valid  input  1  one-cycle award strobe.
- add_value  input  4  award in points, binary 0..15; clamped to MAX_ADD.
- clear_high  input  1  synchronous clear of the high score.
- score_bcd  output  4*NUM_DIGITS  current score, packed BCD, digit 0 in [3:0].
- high_bcd  output  4*NUM_DIGITS  session high score, packed BCD.
- saturated  output  1  high while score_bcd is all nines.
- new_record  output  1  one-cycle pulse when high_bcd is raised.

Behaviour:
- Reset (resetn=0 at a rising edge):
  - score_bcd=0, high_bcd=0, saturated=0, new_record=0, stage register cleared.
  - Reset overrides every other input.
- Score update (stage 1), evaluated each rising edge in this priority:
  1. resetn=0.
  2. enable=0: score_bcd <= 0, saturated <= 0. An award in the same cycle is discarded.
  3. add_valid=1: score_bcd <= score_bcd + min(add_value, MAX_ADD), added in decimal. The add enters digit 0 and carries ripple through all digits within the same cycle.
  4. Otherwise: hold.
- Decimal add rule:
  - Per digit, sum = digit + addend + carry_in.
  - If sum > 9, the digit becomes sum - 10 and carry_out = 1.
  - Addend is the clamped award for digit 0 and 0 for all higher digits.
- Saturation:
  - If the carry out of the top digit is 1, score_bcd is loaded with all nines instead of the wrapped value.
  - saturated is combinationally equal to (score_bcd == all nines), so it rises in the same cycle the score reaches the ceiling.
  - Further awards hold at all nines; the score never wraps.
  - add_value=0 with add_valid=1 leaves the score unchanged and is legal.
- Latency: score_bcd reflects an award on the first rising edge after the add_valid cycle.
- High score (stage 2, one cycle behind the score):
  - Priority order: resetn, then clear_high, then compare.
  - clear_high=1: high_bcd <= 0, new_record <= 0.
  - Else if score_bcd > high_bcd (unsigned compare of the packed vectors, which is valid for BCD): high_bcd <= score_bcd and new_record <= 1 for exactly that cycle.
  - Otherwise new_record <= 0.
  - Consecutive rising scores produce consecutive new_record pulses.
- Simultaneous enable=0 and clear_high=1: both clear in the same cycle.
- enable=0 never changes high_bcd.
- Invalid BCD cannot arise internally. Outputs are always valid BCD.

Decomposition:
- Shared package score_pkg holds:
  - constant BCD_NINE = 4'd9;
  - digit width constant DIGIT_W = 4;
  - function all_nines(NUM_DIGITS) returning the packed ceiling value.
- One natural sub-module: bcd_digit_add.
  - Ports: a[3:0], b[3:0], cin -> s[3:0], cout.
  - Instantiated NUM_DIGITS times in a generate ripple chain.
- Existing per-nibble seven-segment decoders attach externally; they are not instantiated here.

Test Plan (NUM_DIGITS=4, MAX_ADD=9):
- Reset, then 12 awards of 1 -> score_bcd=16'h0012; new_record pulses 12 times; high_bcd=16'h0012.
- From score 16'h0098, add 5 -> score_bcd=16'h0103 (two-digit carry ripple); next cycle high_bcd=16'h0103.
- add_value=15 from 0 -> clamped to 9, score_bcd=16'h0009.
- From 16'h9995, add 9 -> score_bcd=16'h9999 and saturated=1 the same cycle; a further add 3 holds 16'h9999.
- Score 16'h0250, drop enable -> score_bcd=0, high_bcd stays 16'h0250; re-enable, award 3 -> no new_record.
- clear_high with score 16'h0040 -> high_bcd=0; on the next edge high_bcd=16'h0040 with a new_record pulse. Assert resetn=0 mid-award -> all outputs 0.

Source files
------------

// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
//
// Purpose:
//   Shared constants and helpers for the BCD score tracker slice.
//
// Contents:
//   DIGIT_W     - width of one packed BCD digit (4 bits)
//   BCD_NINE    - the largest legal BCD digit value
//   MAX_DIGITS  - widest score any instance may build (8 digits)
//   all_nines() - packed all-nines ceiling for a given digit count, returned
//                 in a MAX_DIGITS-wide vector with the unused digits zeroed
// -----------------------------------------------------------------------------
package score_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] BCD_NINE   = 4'd9;
  localparam int         MAX_DIGITS = 8;

  // Returned at full MAX_DIGITS width so callers can take the low slice
  // that matches their own parameterised score width.
  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] all_nines(input int num_digits);
    logic [DIGIT_W*MAX_DIGITS-1:0] value;
    value = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < num_digits) begin
        value[i*DIGIT_W +: DIGIT_W] = BCD_NINE;
      end
    end
    return value;
  endfunction

endpackage

// File: rtl/bcd_score_tracker_if.sv
// -----------------------------------------------------------------------------
// bcd_score_tracker_if
//
// Purpose:
//   Bundles the award inputs and score outputs shared between the game-logic
//   event generators and the score tracker.
//
// Parameters:
//   NUM_DIGITS - number of BCD digits carried on score_bcd / high_bcd
//
// Signals:
//   enable      game active; low clears the current score
//   add_valid   one-cycle award strobe
//   add_value   award in points, binary 0..15
//   clear_high  synchronous clear of the session high score
//   score_bcd   current score, packed BCD, digit 0 in [3:0]
//   high_bcd    session high score, packed BCD
//   saturated   high while score_bcd is all nines
//   new_record  one-cycle pulse when high_bcd is raised
//
// Modports:
//   master - game logic side (drives awards, observes score)
//   slave  - score tracker side
// -----------------------------------------------------------------------------
interface bcd_score_tracker_if #(
  parameter int NUM_DIGITS = 4
);
  import score_pkg::*;

  logic                            enable;
  logic                            add_valid;
  logic [3:0]                      add_value;
  logic                            clear_high;
  logic [DIGIT_W*NUM_DIGITS-1:0]   score_bcd;
  logic [DIGIT_W*NUM_DIGITS-1:0]   high_bcd;
  logic                            saturated;
  logic                            new_record;

  modport master (
    output enable,
    output add_valid,
    output add_value,
    output clear_high,
    input  score_bcd,
    input  high_bcd,
    input  saturated,
    input  new_record
  );

  modport slave (
    input  enable,
    input  add_valid,
    input  add_value,
    input  clear_high,
    output score_bcd,
    output high_bcd,
    output saturated,
    output new_record
  );

endinterface

// File: rtl/bcd_score_tracker_digit_add.sv
// -----------------------------------------------------------------------------
// bcd_digit_add
//
// Purpose:
//   One decimal digit of a ripple-carry BCD adder. Adds two BCD digits and a
//   carry-in, producing a BCD digit and a decimal carry-out.
//
// Ports:
//   a    [3:0]  input   BCD digit (0..9)
//   b    [3:0]  input   BCD digit (0..9)
//   cin         input   carry from the next-lower digit
//   s    [3:0]  output  BCD sum digit (0..9)
//   cout        output  decimal carry to the next-higher digit
// -----------------------------------------------------------------------------
module bcd_digit_add
  import score_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  // Largest possible sum is 9 + 9 + 1 = 19, so five bits are enough and a
  // single subtract-ten correction always lands back inside 0..9.
  logic [4:0] raw_sum;
  logic [4:0] corrected;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch can never be inferred.
    raw_sum   = 5'(a) + 5'(b) + 5'(cin);
    corrected = raw_sum;
    cout      = 1'b0;
    if (raw_sum > 5'(BCD_NINE)) begin
      corrected = raw_sum - 5'd10;
      cout      = 1'b1;
    end
  end

  assign s = corrected[3:0];

endmodule

// File: rtl/bcd_score_tracker.sv
// -----------------------------------------------------------------------------
// bcd_score_tracker
//
// Purpose:
//   Running game score kept in packed BCD so each nibble feeds a seven-segment
//   decoder directly. Awards are clamped to MAX_ADD, added in decimal with a
//   full ripple through all digits in one cycle, and the score saturates at
//   all nines instead of wrapping. A second stage, one cycle behind the score,
//   tracks the session high score and pulses new_record when it is raised.
//
// Parameters:
//   NUM_DIGITS  number of BCD digits, legal range 1..8
//   MAX_ADD     largest accepted award, legal range 1..9
//
// Ports:
//   clk     input   system clock, all state on the rising edge
//   resetn  input   synchronous, active-low reset
//   bus     slave   award inputs and score outputs (bcd_score_tracker_if)
// -----------------------------------------------------------------------------
module bcd_score_tracker
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_ADD    = 9
) (
  input  logic                  clk,
  input  logic                  resetn,
  bcd_score_tracker_if.slave    bus
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W*MAX_DIGITS-1:0] NINES_FULL = all_nines(NUM_DIGITS);
  localparam logic [W-1:0]                  CEILING    = NINES_FULL[W-1:0];

  // ---------------------------------------------------------------------------
  // Award clamp: only digit 0 receives an addend, so it must be a legal digit.
  // ---------------------------------------------------------------------------
  logic [3:0] addend;

  always_comb begin
    addend = bus.add_value;
    if (bus.add_value > 4'(MAX_ADD)) begin
      addend = 4'(MAX_ADD);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: score register and the decimal ripple adder feeding it.
  // ---------------------------------------------------------------------------
  logic [W-1:0]        score_q;
  logic [W-1:0]        sum_bcd;
  logic [NUM_DIGITS:0] carry;

  assign carry[0] = 1'b0;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [3:0] digit_addend;

    // The award enters only at digit 0; higher digits just absorb carries.
    if (d == 0) begin : g_lsd
      assign digit_addend = addend;
    end else begin : g_upper
      assign digit_addend = 4'd0;
    end

    bcd_digit_add u_add (
      .a    (score_q[d*DIGIT_W +: DIGIT_W]),
      .b    (digit_addend),
      .cin  (carry[d]),
      .s    (sum_bcd[d*DIGIT_W +: DIGIT_W]),
      .cout (carry[d+1])
    );
  end

  // A carry out of the top digit means the true total no longer fits, so the
  // score pins at the ceiling rather than showing the wrapped low digits.
  logic [W-1:0] score_next;

  always_comb begin
    score_next = sum_bcd;
    if (carry[NUM_DIGITS]) begin
      score_next = CEILING;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, matching what the synthesised hardware does.
    if (!resetn) begin
      score_q <= '0;
    end else if (!bus.enable) begin
      score_q <= '0;
    end else if (bus.add_valid) begin
      score_q <= score_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: session high score. Comparing the registered score makes the
  // high score trail the current score by exactly one edge. A plain unsigned
  // compare is correct because BCD digits order the same way binary nibbles do.
  // ---------------------------------------------------------------------------
  logic [W-1:0] high_q;
  logic         new_record_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      high_q       <= '0;
      new_record_q <= 1'b0;
    end else if (bus.clear_high) begin
      high_q       <= '0;
      new_record_q <= 1'b0;
    end else if (score_q > high_q) begin
      high_q       <= score_q;
      new_record_q <= 1'b1;
    end else begin
      new_record_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. saturated is decoded from the score register so it rises in the
  // same cycle the score reaches the ceiling.
  // ---------------------------------------------------------------------------
  assign bus.score_bcd  = score_q;
  assign bus.high_bcd   = high_q;
  assign bus.saturated  = (score_q == CEILING);
  assign bus.new_record = new_record_q;

endmodule

// File: tb/tb_bcd_score_tracker.sv
// -----------------------------------------------------------------------------
// tb_bcd_score_tracker
//
// Self-checking bench for bcd_score_tracker (NUM_DIGITS=4, MAX_ADD=9).
// Inputs change 1 ns after each rising edge; outputs are sampled at the same
// point, i.e. reflecting the edge just taken.
// -----------------------------------------------------------------------------
module tb_bcd_score_tracker;

  logic clk;
  logic resetn;

  int checks = 0;
  int errors = 0;

  bcd_score_tracker_if #(.NUM_DIGITS(4)) bus ();

  bcd_score_tracker #(
    .NUM_DIGITS (4),
    .MAX_ADD    (9)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        av;
    logic [3:0]  val;
    logic        ch;
    logic [15:0] exp_score;
    logic [15:0] exp_high;
    logic        exp_sat;
    logic        exp_new;
  } vec_t;

  localparam int NUM_VECS = 17;
  vec_t vecs [NUM_VECS];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_n(input logic [3:0] value, input int count);
    for (int i = 0; i < count; i++) begin
      bus.add_valid = 1'b1;
      bus.add_value = value;
      step();
    end
    bus.add_valid = 1'b0;
    bus.add_value = 4'd0;
  endtask

  task automatic check_all(input string tag, input logic [15:0] s, input logic [15:0] h,
                           input logic sat, input logic nr);
    check({tag, ".score"},      32'(bus.score_bcd),  32'(s));
    check({tag, ".high"},       32'(bus.high_bcd),   32'(h));
    check({tag, ".saturated"},  32'(bus.saturated),  32'(sat));
    check({tag, ".new_record"}, 32'(bus.new_record), 32'(nr));
  endtask

  initial begin
    // Twelve awards of 1: high trails score by one edge, new_record from the
    // second edge on, then the high catches up on the first idle edge.
    vecs[0]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0002, 16'h0001, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0003, 16'h0002, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0004, 16'h0003, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0005, 16'h0004, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0006, 16'h0005, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0007, 16'h0006, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0008, 16'h0007, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0009, 16'h0008, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0010, 16'h0009, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0011, 16'h0010, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 4'd1,  1'b0, 16'h0012, 16'h0011, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 4'd0,  1'b0, 16'h0012, 16'h0012, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 4'd0,  1'b0, 16'h0012, 16'h0012, 1'b0, 1'b0};
    // enable low with a simultaneous award: award discarded, high kept.
    vecs[14] = '{1'b0, 1'b1, 4'd5,  1'b0, 16'h0000, 16'h0012, 1'b0, 1'b0};
    // add_value 15 clamps to 9.
    vecs[15] = '{1'b1, 1'b1, 4'd15, 1'b0, 16'h0009, 16'h0012, 1'b0, 1'b0};
    // add_value 0 with add_valid leaves the score unchanged.
    vecs[16] = '{1'b1, 1'b1, 4'd0,  1'b0, 16'h0009, 16'h0012, 1'b0, 1'b0};

    resetn         = 1'b0;
    bus.enable     = 1'b1;
    bus.add_valid  = 1'b1;
    bus.add_value  = 4'd9;
    bus.clear_high = 1'b0;
    step();
    step();
    check_all("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

    resetn        = 1'b1;
    bus.add_valid = 1'b0;
    bus.add_value = 4'd0;

    for (int i = 0; i < NUM_VECS; i++) begin
      bus.enable     = vecs[i].en;
      bus.add_valid  = vecs[i].av;
      bus.add_value  = vecs[i].val;
      bus.clear_high = vecs[i].ch;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_score, vecs[i].exp_high,
                vecs[i].exp_sat, vecs[i].exp_new);
    end
    bus.enable     = 1'b1;
    bus.add_valid  = 1'b0;
    bus.add_value  = 4'd0;
    bus.clear_high = 1'b0;

    // 0098 + 5 -> 0103: carry ripples through two digits in one edge.
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
    add_n(4'd9, 10);
    add_n(4'd8, 1);
    check("ripple.pre", 32'(bus.score_bcd), 32'h0098);
    add_n(4'd5, 1);
    check("ripple.score", 32'(bus.score_bcd), 32'h0103);
    step();
    check("ripple.high", 32'(bus.high_bcd), 32'h0103);
    check("ripple.new_record", 32'(bus.new_record), 32'h1);

    // 9995 + 9 saturates to 9999 the same edge; further awards hold.
    bus.enable = 1'b0;
    step();
    bus.enable = 1'b1;
    add_n(4'd9, 1110);
    add_n(4'd5, 1);
    check("sat.pre_score", 32'(bus.score_bcd), 32'h9995);
    check("sat.pre_flag", 32'(bus.saturated), 32'h0);
    add_n(4'd9, 1);
    check("sat.score", 32'(bus.score_bcd), 32'h9999);
    check("sat.flag", 32'(bus.saturated), 32'h1);
    add_n(4'd3, 1);
    check("sat.hold_score", 32'(bus.score_bcd), 32'h9999);
    check("sat.hold_flag", 32'(bus.saturated), 32'h1);

    // enable low and clear_high together clear both registers.
    bus.enable     = 1'b0;
    bus.clear_high = 1'b1;
    step();
    check_all("dual_clear", 16'h0000, 16'h0000, 1'b0, 1'b0);
    bus.enable     = 1'b1;
    bus.clear_high = 1'b0;

    // Score 0250, drop enable, re-enable and award 3: high stays, no record.
    add_n(4'd9, 27);
    add_n(4'd7, 1);
    step();
    check("hold250.high", 32'(bus.high_bcd), 32'h0250);
    bus.enable = 1'b0;
    step();
    check("hold250.score_cleared", 32'(bus.score_bcd), 32'h0000);
    check("hold250.high_kept", 32'(bus.high_bcd), 32'h0250);
    bus.enable = 1'b1;
    add_n(4'd3, 1);
    check("hold250.score3", 32'(bus.score_bcd), 32'h0003);
    check("hold250.no_record_a", 32'(bus.new_record), 32'h0);
    step();
    check("hold250.no_record_b", 32'(bus.new_record), 32'h0);
    check("hold250.high_after", 32'(bus.high_bcd), 32'h0250);

    // clear_high at score 0040, then the high reloads with a record pulse.
    add_n(4'd9, 4);
    add_n(4'd1, 1);
    step();
    check("clrhigh.score", 32'(bus.score_bcd), 32'h0040);
    bus.clear_high = 1'b1;
    step();
    check("clrhigh.high_zero", 32'(bus.high_bcd), 32'h0000);
    check("clrhigh.no_record", 32'(bus.new_record), 32'h0);
    bus.clear_high = 1'b0;
    step();
    check("clrhigh.high_reload", 32'(bus.high_bcd), 32'h0040);
    check("clrhigh.record", 32'(bus.new_record), 32'h1);

    // Reset in the middle of an award overrides everything.
    bus.add_valid = 1'b1;
    bus.add_value = 4'd7;
    resetn        = 1'b0;
    step();
    check_all("mid_reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    resetn        = 1'b1;
    bus.add_valid = 1'b0;
    bus.add_value = 4'd0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
